// File: rtl/bpb_pkg.sv
// bpb_pkg: shared types and sizes for the predictor update scheduler.
// Macro BPB_T sets the branch tag width; it defaults to 32 when not defined.
`ifndef BPB_T
`define BPB_T 32
`endif

package bpb_pkg;

  localparam int BPB_TAG_W     = `BPB_T;
  localparam int BPB_UPD_DEPTH = 4;

  typedef struct packed {
    logic [BPB_TAG_W-1:0] pc;
    logic                 taken;
    logic [31:0]          addr;
    logic                 mistake;
  } bpb_upd_t;

endpackage

// File: rtl/bpb_upd_fifo.sv
// bpb_upd_fifo: dual-write, single-read circular buffer of updates.
// Write port 1 lands after port 0 when both fire; DEPTH is a power of two.
module bpb_upd_fifo
  import bpb_pkg::*;
#(
  parameter int DEPTH = BPB_UPD_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             wr_en,
  input  bpb_upd_t               wr_data [2],
  input  logic                   rd_en,
  output bpb_upd_t               rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  bpb_upd_t      mem_q [DEPTH];
  bpb_upd_t      mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW-1:0] wr1_ptr;

  // Next-state: two in-order writes, one read, pointers wrap naturally.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    wr1_ptr = tail_q + PW'(wr_en[0]);
    if (wr_en[0]) mem_d[tail_q] = wr_data[0];
    if (wr_en[1]) mem_d[wr1_ptr] = wr_data[1];
    tail_d = tail_q + PW'(wr_en[0]) + PW'(wr_en[1]);
    if (rd_en) head_d = head_q + PW'(1);
    cnt_d = cnt_q
          + (PW+1)'(wr_en[0])
          + (PW+1)'(wr_en[1])
          - (PW+1)'(rd_en);
  end

  // Control state; reset drops every queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage needs no reset; count gates what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[head_q];
  assign count   = cnt_q;

endmodule

// File: rtl/bpb_update_sched.sv
// bpb_update_sched: funnels two resolve lanes into the single predictor update port.
// Define BPB_UPD_BYPASS_EN to let a lone lane-0 update skip the queue when idle.
module bpb_update_sched
  import bpb_pkg::*;
#(
  parameter int TAG_WIDTH = BPB_TAG_W,
  parameter int DEPTH     = BPB_UPD_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  output logic                   in_ready,
  input  logic                   r0_valid,
  input  logic                   r1_valid,
  input  logic [TAG_WIDTH-1:0]   r0_pc,
  input  logic [TAG_WIDTH-1:0]   r1_pc,
  input  logic                   r0_taken,
  input  logic                   r1_taken,
  input  logic [31:0]            r0_addr,
  input  logic [31:0]            r1_addr,
  input  logic                   r0_mistake,
  input  logic                   r1_mistake,
  output logic                   upd_valid,
  output logic [TAG_WIDTH-1:0]   upd_pc,
  output logic                   upd_taken,
  output logic [31:0]            upd_addr,
  output logic                   upd_mistake,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] cnt;
  logic          squash;
  logic          acc0;
  logic          acc1;
  logic          q_valid;
  logic          byp;
  logic [1:0]    wr_en;
  bpb_upd_t      wr_data [2];
  bpb_upd_t      lane0;
  bpb_upd_t      lane1;
  bpb_upd_t      head;
  bpb_upd_t      upd;

  assign in_ready = (cnt <= CW'(DEPTH - 2));

  // Accept, squash the younger lane behind a mispredict, pick the update source.
  always_comb begin
    lane0.pc      = BPB_TAG_W'(r0_pc);
    lane0.taken   = r0_taken;
    lane0.addr    = r0_addr;
    lane0.mistake = r0_mistake;
    lane1.pc      = BPB_TAG_W'(r1_pc);
    lane1.taken   = r1_taken;
    lane1.addr    = r1_addr;
    lane1.mistake = r1_mistake;
    squash  = r0_valid & r0_mistake;
    acc0    = r0_valid & in_ready;
    acc1    = r1_valid & in_ready & ~squash;
    q_valid = (cnt != '0) & ~stall;
`ifdef BPB_UPD_BYPASS_EN
    byp     = acc0 & (cnt == '0) & ~stall;
`else
    byp     = 1'b0;
`endif
    wr_en      = {acc1, acc0 & ~byp};
    wr_data[0] = lane0;
    wr_data[1] = lane1;
    upd_valid  = q_valid | byp;
    upd        = byp ? lane0 : head;
    if (!upd_valid) upd = '0;
  end

  bpb_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (q_valid),
    .rd_data (head),
    .count   (cnt)
  );

  assign upd_pc      = TAG_WIDTH'(upd.pc);
  assign upd_taken   = upd.taken;
  assign upd_addr    = upd.addr;
  assign upd_mistake = upd.mistake;
  assign occupancy   = cnt;

endmodule

// File: tb/tb_bpb_update_sched.sv
// tb_bpb_update_sched: scoreboard bench for the predictor update scheduler.
// Builds with or without BPB_UPD_BYPASS_EN; the model follows the same macro.
module tb_bpb_update_sched;
  import bpb_pkg::*;

  localparam int D  = BPB_UPD_DEPTH;
  localparam int TW = BPB_TAG_W;

  logic                clk = 1'b0;
  logic                reset;
  logic                stall;
  logic                in_ready;
  logic                r0_valid, r1_valid;
  logic [TW-1:0]       r0_pc, r1_pc;
  logic                r0_taken, r1_taken;
  logic [31:0]         r0_addr, r1_addr;
  logic                r0_mistake, r1_mistake;
  logic                upd_valid;
  logic [TW-1:0]       upd_pc;
  logic                upd_taken;
  logic [31:0]         upd_addr;
  logic                upd_mistake;
  logic [$clog2(D):0]  occupancy;

  always #5 clk = ~clk;

  bpb_update_sched dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .in_ready    (in_ready),
    .r0_valid    (r0_valid),
    .r1_valid    (r1_valid),
    .r0_pc       (r0_pc),
    .r1_pc       (r1_pc),
    .r0_taken    (r0_taken),
    .r1_taken    (r1_taken),
    .r0_addr     (r0_addr),
    .r1_addr     (r1_addr),
    .r0_mistake  (r0_mistake),
    .r1_mistake  (r1_mistake),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_addr    (upd_addr),
    .upd_mistake (upd_mistake),
    .occupancy   (occupancy)
  );

  bpb_upd_t sb [$];
  int       checks = 0;
  int       errors = 0;
  int       mcnt = 0;
  int       mcnt_nxt = 0;
  int       max_occ = 0;
  logic     exp_v = 1'b0;
  bit       clr_pend = 1'b0;
  bit       mon_en = 1'b0;
  bpb_upd_t z = '0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bpb_upd_t mk(input logic [TW-1:0] pc, input logic t,
                                  input logic [31:0] a, input logic m);
    bpb_upd_t e;
    e.pc = pc; e.taken = t; e.addr = a; e.mistake = m;
    return e;
  endfunction

  function automatic bpb_upd_t rnd(input logic m);
    return mk(TW'($urandom), 1'($urandom), $urandom, m);
  endfunction

  // Monitor: compares every cycle, pops the scoreboard on each presented update.
  always @(negedge clk) begin
    bpb_upd_t e;
    if (mon_en) begin
      chk("occupancy", 128'(occupancy), 128'(mcnt));
      chk("in_ready", 128'(in_ready), 128'(mcnt <= D - 2));
      chk("upd_valid", 128'(upd_valid), 128'(exp_v));
      if (upd_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update actual=%0h required=none", upd_pc);
        end else begin
          e = sb.pop_front();
          chk("upd_pc", 128'(upd_pc), 128'(e.pc));
          chk("upd_taken", 128'(upd_taken), 128'(e.taken));
          chk("upd_addr", 128'(upd_addr), 128'(e.addr));
          chk("upd_mistake", 128'(upd_mistake), 128'(e.mistake));
        end
      end else begin
        chk("idle_fields", 128'({upd_pc, upd_taken, upd_addr, upd_mistake}), 128'(0));
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end
  end

  // One cycle of stimulus; the model decides what is accepted and presented.
  task automatic step(input logic st, input logic rs, input logic v0,
                      input bpb_upd_t e0, input logic v1, input bpb_upd_t e1);
    logic rdy, a0, a1;
    @(posedge clk);
    mcnt = mcnt_nxt;
    if (clr_pend) begin
      sb.delete();
      clr_pend = 1'b0;
    end
    #1;
    reset      = rs;
    stall      = st;
    r0_valid   = v0;
    r0_pc      = e0.pc;
    r0_taken   = e0.taken;
    r0_addr    = e0.addr;
    r0_mistake = e0.mistake;
    r1_valid   = v1;
    r1_pc      = e1.pc;
    r1_taken   = e1.taken;
    r1_addr    = e1.addr;
    r1_mistake = e1.mistake;
    rdy = (mcnt <= D - 2);
    a0  = v0 & rdy & ~rs;
    a1  = v1 & rdy & ~(v0 & e0.mistake) & ~rs;
`ifdef BPB_UPD_BYPASS_EN
    exp_v = ~st & ((mcnt != 0) | a0);
`else
    exp_v = ~st & (mcnt != 0);
`endif
    if (a0) sb.push_back(e0);
    if (a1) sb.push_back(e1);
    if (rs) begin
      mcnt_nxt = 0;
      clr_pend = 1'b1;
    end else begin
      mcnt_nxt = mcnt + int'(a0) + int'(a1) - int'(exp_v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, z, 1'b0, z);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_pc = '0; r1_pc = '0; r0_taken = 1'b0; r1_taken = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_mistake = 1'b0; r1_mistake = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    idle(5);

    step(1'b0, 1'b0, 1'b1, mk(TW'(32'h10), 1'b1, 32'h400, 1'b0), 1'b0, z);
    idle(3);

    max_occ = 0;
    step(1'b0, 1'b0, 1'b1, mk(TW'(32'h20), 1'b0, 32'h500, 1'b1),
         1'b1, mk(TW'(32'h24), 1'b1, 32'h600, 1'b0));
    idle(3);
    chk("squash_max_occ", 128'(max_occ <= 1), 128'(1));

    step(1'b1, 1'b0, 1'b1, mk(TW'(32'h30), 1'b1, 32'h700, 1'b0),
         1'b1, mk(TW'(32'h34), 1'b0, 32'h704, 1'b0));
    step(1'b1, 1'b0, 1'b1, mk(TW'(32'h38), 1'b1, 32'h708, 1'b0),
         1'b1, mk(TW'(32'h3c), 1'b0, 32'h70c, 1'b1));
    step(1'b1, 1'b0, 1'b1, mk(TW'(32'h99), 1'b1, 32'hbad, 1'b0), 1'b0, z);
    idle(6);

    step(1'b1, 1'b0, 1'b1, mk(TW'(32'h40), 1'b1, 32'h800, 1'b0),
         1'b1, mk(TW'(32'h44), 1'b0, 32'h804, 1'b0));
    step(1'b1, 1'b0, 1'b1, mk(TW'(32'h48), 1'b1, 32'h808, 1'b0), 1'b0, z);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, z, 1'b0, z);
    idle(4);

    step(1'b1, 1'b0, 1'b1, mk(TW'(32'h50), 1'b1, 32'h900, 1'b0),
         1'b1, mk(TW'(32'h54), 1'b0, 32'h904, 1'b0));
    step(1'b1, 1'b0, 1'b1, mk(TW'(32'h58), 1'b1, 32'h908, 1'b0), 1'b0, z);
    step(1'b1, 1'b1, 1'b0, z, 1'b0, z);
    idle(1);
    step(1'b0, 1'b0, 1'b1, mk(TW'(32'h60), 1'b0, 32'ha00, 1'b0), 1'b0, z);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic st, rs, v0, v1, m0;
      st = ($urandom_range(3) == 0);
      rs = ($urandom_range(63) == 0);
      v0 = rs ? 1'b0 : 1'($urandom);
      v1 = rs ? 1'b0 : 1'($urandom);
      m0 = ($urandom_range(3) == 0);
      step(st, rs, v0, rnd(m0), v1, rnd(1'($urandom)));
    end
    idle(8);
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
